// File: rtl/booth_r4_mult_param.sv
// Sequential radix-4 Booth multiplier, WIDTH-bit operands, signed or unsigned per operation.
// One Booth digit per CALC cycle; the product is held in z behind a ready/valid handshake.
module booth_r4_mult_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 in_ready,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   z,
    output logic                 valid,
    input  logic                 z_ready,
    output logic                 cg_en
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [EW-1:0]  acc;
    logic signed [EW-1:0]  q_reg;
    logic signed [EW-1:0]  m_reg;
    logic                  q_m1;
    logic [CW-1:0]         count;

    logic signed [EW:0]    sum;
    logic signed [EW-1:0]  acc_nxt;
    logic signed [EW-1:0]  q_nxt;
    logic [2*WIDTH-1:0]    z_nxt;
    logic                  last_iter;

    function automatic logic signed [EW-1:0] ext_op(input logic [WIDTH-1:0] v, input logic sm);
        return sm ? $signed({{2{v[WIDTH-1]}}, v}) : $signed({2'b00, v});
    endfunction

    // Radix-4 digit selection; computed one bit wider than M so +/-2M stays exact.
    function automatic logic signed [EW:0] booth_term(input logic [2:0] trip,
                                                      input logic signed [EW-1:0] m);
        logic signed [EW:0] m1;
        m1 = $signed({m[EW-1], m});
        case (trip)
            3'b001, 3'b010: return m1;
            3'b011:         return m1 <<< 1;
            3'b100:         return -(m1 <<< 1);
            3'b101, 3'b110: return -m1;
            default:        return '0;
        endcase
    endfunction

    assign sum       = $signed({acc[EW-1], acc}) + booth_term({q_reg[1:0], q_m1}, m_reg);
    assign acc_nxt   = $signed({sum[EW], sum[EW:2]});
    assign q_nxt     = $signed({sum[1:0], q_reg[EW-1:2]});
    assign z_nxt     = {acc_nxt[WIDTH-3:0], q_nxt};
    assign last_iter = (count == CW'(ITER - 1));

    assign in_ready = (state == IDLE);
    assign busy     = (state == CALC);
    assign cg_en    = (state == CALC) | ((state == IDLE) & start) | rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    if (z_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: only change on capture or iteration, so cg_en may gate their clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (state == IDLE && start) begin
            acc   <= '0;
            q_reg <= ext_op(x, signed_mode);
            q_m1  <= 1'b0;
            m_reg <= ext_op(y, signed_mode);
            count <= '0;
        end else if (state == CALC) begin
            acc   <= acc_nxt;
            q_reg <= q_nxt;
            q_m1  <= q_reg[1];
            count <= count + 1'b1;
        end
    end

    // Result registers stay on the free-running clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            z     <= '0;
            valid <= 1'b0;
        end else if (state == CALC && last_iter) begin
            z     <= z_nxt;
            valid <= 1'b1;
        end else if (state == DONE && z_ready) begin
            valid <= 1'b0;
        end
    end

endmodule
